garduino_pio_gp: RTL and testbench



---
 rtl/garduino_pio_pkg.sv | 13 +
 rtl/garduino_pio_edge_sync.sv | 36 +++
 rtl/garduino_pio_gp.sv | 85 ++++++++
 tb/tb_garduino_pio_gp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/garduino_pio_pkg.sv
// garduino_pio_pkg: register addresses, edge-type codes and width limit shared by the PIO blocks
package garduino_pio_pkg;
    localparam logic [2:0] PIO_ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] PIO_ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR   = 3'd5;
    localparam int EDGE_RISE     = 0;
    localparam int EDGE_FALL     = 1;
    localparam int EDGE_ANY      = 2;
    localparam int PIO_MAX_WIDTH = 32;
endpackage

// File: rtl/garduino_pio_edge_sync.sv
// garduino_pio_edge_sync: multi-flop input synchroniser, one-cycle history and per-bit edge detect
module garduino_pio_edge_sync
    import garduino_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] det
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] pipe;
    logic [WIDTH-1:0]                  prev;

    assign sync = pipe[SYNC_STAGES-1];

    // shift the raw inputs through the synchroniser and keep last cycle's synchronised value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
            prev <= '0;
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0], in_port};
            prev <= sync;
        end
    end

    // select the configured edge polarity
    always_comb begin
        det = EDGE_TYPE == EDGE_RISE ? (sync & ~prev) :
              EDGE_TYPE == EDGE_FALL ? (~sync & prev) : (sync ^ prev);
    end
endmodule

// File: rtl/garduino_pio_gp.sv
// garduino_pio_gp: Avalon-MM general-purpose PIO with edge capture, maskable irq and
// optional atomic output set/clear (enabled by GARDUINO_PIO_BITSET_EN)
module garduino_pio_gp
    import garduino_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    logic             wr;
    logic             unused;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_out_nxt;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] rd;

    assign wr       = chipselect & ~write_n;
    assign wd       = writedata[WIDTH-1:0];
    assign unused   = ^writedata;
    assign clr      = (wr && address == PIO_ADDR_EDGE_CAP) ? wd : '0;
    assign out_port = data_out;
    assign readdata = 32'(rd);

    garduino_pio_edge_sync #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .sync   (sync),
        .det    (det)
    );

    // next output value: plain write, plus atomic set/clear when enabled
    always_comb begin
        data_out_nxt = data_out;
        if (wr && address == PIO_ADDR_DATA_OUT) data_out_nxt = wd;
`ifdef GARDUINO_PIO_BITSET_EN
        if (wr && address == PIO_ADDR_OUTSET) data_out_nxt = data_out | wd;
        if (wr && address == PIO_ADDR_OUTCLR) data_out_nxt = data_out & ~wd;
`endif
    end

    // register file and irq; a fresh edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            data_out <= data_out_nxt;
            if (wr && address == PIO_ADDR_IRQ_MASK) irq_mask <= wd;
            edge_cap <= (edge_cap & ~clr) | det;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    // zero-wait read mux; write-only and unused addresses read zero
    always_comb begin
        rd = address == PIO_ADDR_DATA_OUT ? data_out :
             address == PIO_ADDR_DATA_IN  ? sync     :
             address == PIO_ADDR_IRQ_MASK ? irq_mask :
             address == PIO_ADDR_EDGE_CAP ? edge_cap : '0;
    end
endmodule

// File: tb/tb_garduino_pio_gp.sv
// tb_garduino_pio_gp: table-driven register checks plus edge/irq/reset sequences on 8-bit and 32-bit instances
module tb_garduino_pio_gp;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] rd8, rd32;
    logic [7:0]  in8 = '0, out8;
    logic [31:0] in32 = '0, out32;
    logic        irq8, irq32;
    int          compared = 0;
    int          mismatched = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  out;
    } exp_t;

    vec_t tab[14];
    exp_t sb[$];

    always #5 clk = ~clk;

    garduino_pio_gp #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .in_port(in8), .out_port(out8), .irq(irq8)
    );

    garduino_pio_gp #(.WIDTH(32), .RESET_VALUE(32'h8000_0001), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd32),
        .in_port(in32), .out_port(out32), .irq(irq32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_addr(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] o5, o7;
        exp_t e;
`ifdef GARDUINO_PIO_BITSET_EN
        o5 = 8'hF0;
        o7 = 8'hFA;
`else
        o5 = 8'hFF;
        o7 = 8'hFF;
`endif
        tab[0]  = '{1'b0, 3'd0, 32'h0,   32'hA5, 8'hA5};
        tab[1]  = '{1'b0, 3'd2, 32'h0,   32'h00, 8'hA5};
        tab[2]  = '{1'b0, 3'd3, 32'h0,   32'h00, 8'hA5};
        tab[3]  = '{1'b1, 3'd0, 32'h1FF, 32'hFF, 8'hFF};
        tab[4]  = '{1'b1, 3'd4, 32'h00,  32'h00, 8'hFF};
        tab[5]  = '{1'b1, 3'd5, 32'h0F,  32'h00, o5};
        tab[6]  = '{1'b0, 3'd0, 32'h0,   32'(o5), o5};
        tab[7]  = '{1'b1, 3'd4, 32'h0A,  32'h00, o7};
        tab[8]  = '{1'b1, 3'd7, 32'h55,  32'h00, o7};
        tab[9]  = '{1'b1, 3'd0, 32'h3C,  32'h3C, 8'h3C};
        tab[10] = '{1'b1, 3'd1, 32'hFF,  32'h00, 8'h3C};
        tab[11] = '{1'b1, 3'd2, 32'h1AB, 32'hAB, 8'h3C};
        tab[12] = '{1'b1, 3'd2, 32'h000, 32'h00, 8'h3C};
        tab[13] = '{1'b1, 3'd6, 32'hFF,  32'h00, 8'h3C};

        step(2);
        check("reset out8", 32'(out8), 32'hA5);
        check("reset irq8", 32'(irq8), 32'h0);
        check("reset out32", out32, 32'h8000_0001);
        reset_n = 1'b1;
        step(1);

        for (int i = 0; i < 14; i++) begin
            if (tab[i].wr) bus_write(tab[i].addr, tab[i].wdata);
            sb.push_back('{tab[i].exp_rd, tab[i].exp_out});
            rd_addr(tab[i].addr);
            e = sb.pop_front();
            check($sformatf("vec%0d rd", i), rd8, e.rd);
            check($sformatf("vec%0d out", i), 32'(out8), 32'(e.out));
        end
        chipselect = 1'b0;

        in8 = 8'h04;
        step(1);
        rd_addr(1); check("data_in clk1", rd8, 32'h00);
        step(1);
        rd_addr(1); check("data_in clk2", rd8, 32'h04);
        rd_addr(3); check("edge_cap clk2", rd8, 32'h00);
        step(1);
        rd_addr(3); check("edge_cap clk3", rd8, 32'h04);
        check("irq masked clk3", 32'(irq8), 32'h0);
        step(1);
        check("irq masked clk4", 32'(irq8), 32'h0);
        bus_write(2, 32'h04);
        check("irq mask write edge", 32'(irq8), 32'h0);
        step(1);
        check("irq after mask", 32'(irq8), 32'h1);

        bus_write(3, 32'h04);
        rd_addr(3); check("w1c edge_cap", rd8, 32'h00);
        check("irq w1c same clk", 32'(irq8), 32'h1);
        step(1);
        check("irq after w1c", 32'(irq8), 32'h0);

        in8 = 8'h00;
        step(3);
        in8 = 8'h04;
        step(4);
        rd_addr(3); check("recapture", rd8, 32'h04);
        check("irq recapture", 32'(irq8), 32'h1);
        in8 = 8'h00;
        step(3);
        rd_addr(3); check("fall ignored sticky", rd8, 32'h04);
        in8 = 8'h04;
        step(2);
        bus_write(3, 32'h04);
        rd_addr(3); check("set wins over clear", rd8, 32'h04);
        check("irq set wins", 32'(irq8), 32'h1);
        step(1);
        check("irq held set wins", 32'(irq8), 32'h1);
        bus_write(3, 32'h04);
        rd_addr(3); check("w1c no edge", rd8, 32'h00);

        bus_write(2, 32'h8000_0000);
        in32 = 32'h8000_0000;
        step(2);
        rd_addr(1); check("w32 data_in", rd32, 32'h8000_0000);
        step(1);
        rd_addr(3); check("w32 rise cap", rd32, 32'h8000_0000);
        step(1);
        check("w32 irq rise", 32'(irq32), 32'h1);
        bus_write(3, 32'h8000_0000);
        rd_addr(3); check("w32 cleared", rd32, 32'h0);
        step(1);
        check("w32 irq cleared", 32'(irq32), 32'h0);
        in32 = 32'h0;
        step(3);
        rd_addr(3); check("w32 fall cap", rd32, 32'h8000_0000);
        step(1);
        check("w32 irq fall", 32'(irq32), 32'h1);

        #1 reset_n = 1'b0;
        #1;
        check("async rst irq32", 32'(irq32), 32'h0);
        check("async rst cap32", rd32, 32'h0);
        check("async rst out32", out32, 32'h8000_0001);
        check("async rst out8", 32'(out8), 32'hA5);
        check("async rst irq8", 32'(irq8), 32'h0);
        step(1);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
